// File: rtl/rs_issue_queue.sv
// Reservation station: holds dispatched uOPs until both sources are ready, issues the oldest ready one.
// Latency: dispatch (sources ready) or wakeup in cycle N -> issuable in cycle N+1; issue outputs are combinational from state.
// Backpressure: disp_ready drops when every entry is occupied; iss_ready low leaves the selected entry resident.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   flush              drop every resident entry at the next edge
//   disp_*             dispatch valid/ready handshake plus uOP fields (source tags, ready flags, dest, opcode, imm)
//   wake_valid/tag     per-FU wakeup broadcasts, port k at wake_tag[k*PREG_W +: PREG_W]
//   iss_*              issue valid/ready handshake plus the selected uOP's fields (zero when nothing selected)
//   occupancy          number of resident entries
module rs_issue_queue #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_PREGS  = 128,
    parameter int NUM_WAKEUP = 4,
    parameter int OPC_W      = 6,
    parameter int IMM_W      = 32,
    localparam int PREG_W    = $clog2(NUM_PREGS),
    localparam int OCC_W     = $clog2(RS_ENTRIES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [PREG_W-1:0]            disp_src1_idx,
    input  logic [PREG_W-1:0]            disp_src2_idx,
    input  logic                         disp_src1_rdy,
    input  logic                         disp_src2_rdy,
    input  logic [PREG_W-1:0]            disp_dst_idx,
    input  logic [OPC_W-1:0]             disp_opcode,
    input  logic [IMM_W-1:0]             disp_imm,
    input  logic [NUM_WAKEUP-1:0]        wake_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wake_tag,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PREG_W-1:0]            iss_src1_idx,
    output logic [PREG_W-1:0]            iss_src2_idx,
    output logic [PREG_W-1:0]            iss_dst_idx,
    output logic [OPC_W-1:0]             iss_opcode,
    output logic [IMM_W-1:0]             iss_imm,
    output logic [OCC_W-1:0]             occupancy
);

    logic [RS_ENTRIES-1:0] valid_q, valid_d;
    logic [RS_ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
    logic [RS_ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
    logic [PREG_W-1:0]     src1_q [RS_ENTRIES];
    logic [PREG_W-1:0]     src1_d [RS_ENTRIES];
    logic [PREG_W-1:0]     src2_q [RS_ENTRIES];
    logic [PREG_W-1:0]     src2_d [RS_ENTRIES];
    logic [PREG_W-1:0]     dst_q  [RS_ENTRIES];
    logic [PREG_W-1:0]     dst_d  [RS_ENTRIES];
    logic [OPC_W-1:0]      opc_q  [RS_ENTRIES];
    logic [OPC_W-1:0]      opc_d  [RS_ENTRIES];
    logic [IMM_W-1:0]      imm_q  [RS_ENTRIES];
    logic [IMM_W-1:0]      imm_d  [RS_ENTRIES];
    // age_q[i][j] = 1 : entry i is older than entry j
    logic [RS_ENTRIES-1:0] age_q  [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] age_d  [RS_ENTRIES];
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic [RS_ENTRIES-1:0] cand, grant, free_oh;
    logic                  disp_fire, iss_fire;

    function automatic logic wake_hit(input logic [PREG_W-1:0] tag,
                                      input logic [NUM_WAKEUP-1:0] wv,
                                      input logic [NUM_WAKEUP*PREG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (wv[k] && (wt[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Age matrix is a total order over valid entries, so at most one candidate wins.
    always_comb begin
        grant = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (j != i && cand[j] && !age_q[i][j]) grant[i] = 1'b0;
            end
        end
    end

    always_comb begin
        logic found;
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!valid_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign cand       = valid_q & s1_rdy_q & s2_rdy_q;
    assign disp_ready = (occ_q < OCC_W'(RS_ENTRIES));
    assign iss_valid  = (|cand) & ~flush;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign iss_fire   = iss_valid & iss_ready;
    assign occupancy  = occ_q;

    always_comb begin
        iss_src1_idx = '0;
        iss_src2_idx = '0;
        iss_dst_idx  = '0;
        iss_opcode   = '0;
        iss_imm      = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (grant[i] && !flush) begin
                iss_src1_idx = src1_q[i];
                iss_src2_idx = src2_q[i];
                iss_dst_idx  = dst_q[i];
                iss_opcode   = opc_q[i];
                iss_imm      = imm_q[i];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        opc_d    = opc_q;
        imm_d    = imm_q;
        age_d    = age_q;
        occ_d    = occ_q;

        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (valid_q[i] && wake_hit(src1_q[i], wake_valid, wake_tag)) s1_rdy_d[i] = 1'b1;
            if (valid_q[i] && wake_hit(src2_q[i], wake_valid, wake_tag)) s2_rdy_d[i] = 1'b1;
        end

        if (iss_fire) valid_d = valid_d & ~grant;

        if (disp_fire) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (free_oh[i]) begin
                    valid_d[i]  = 1'b1;
                    src1_d[i]   = disp_src1_idx;
                    src2_d[i]   = disp_src2_idx;
                    dst_d[i]    = disp_dst_idx;
                    opc_d[i]    = disp_opcode;
                    imm_d[i]    = disp_imm;
                    // x0 is hardwired ready; a concurrent broadcast is bypassed into the entry
                    s1_rdy_d[i] = disp_src1_rdy || (disp_src1_idx == '0) ||
                                  wake_hit(disp_src1_idx, wake_valid, wake_tag);
                    s2_rdy_d[i] = disp_src2_rdy || (disp_src2_idx == '0) ||
                                  wake_hit(disp_src2_idx, wake_valid, wake_tag);
                    // Newcomer is younger than everything already resident
                    age_d[i] = '0;
                    for (int j = 0; j < RS_ENTRIES; j++) age_d[j][i] = valid_q[j];
                end
            end
        end

        case ({disp_fire, iss_fire})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                src1_q[i] <= '0;
                src2_q[i] <= '0;
                dst_q[i]  <= '0;
                opc_q[i]  <= '0;
                imm_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            s1_rdy_q <= s1_rdy_d;
            s2_rdy_q <= s2_rdy_d;
            occ_q    <= occ_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            opc_q    <= opc_d;
            imm_q    <= imm_d;
            age_q    <= age_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue with default parameters.
// Inputs change at the falling edge; outputs are sampled 1ns later.
// Each test states the expected values computed by hand from the queue behaviour.
module tb_rs_issue_queue;

    localparam int PW = 7;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          disp_valid;
    logic          disp_ready;
    logic [PW-1:0] disp_src1_idx, disp_src2_idx, disp_dst_idx;
    logic          disp_src1_rdy, disp_src2_rdy;
    logic [5:0]    disp_opcode;
    logic [31:0]   disp_imm;
    logic [3:0]    wake_valid;
    logic [4*PW-1:0] wake_tag;
    logic          iss_valid;
    logic          iss_ready;
    logic [PW-1:0] iss_src1_idx, iss_src2_idx, iss_dst_idx;
    logic [5:0]    iss_opcode;
    logic [31:0]   iss_imm;
    logic [3:0]    occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    rs_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_idx(disp_src1_idx), .disp_src2_idx(disp_src2_idx),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_dst_idx(disp_dst_idx), .disp_opcode(disp_opcode), .disp_imm(disp_imm),
        .wake_valid(wake_valid), .wake_tag(wake_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src1_idx(iss_src1_idx), .iss_src2_idx(iss_src2_idx),
        .iss_dst_idx(iss_dst_idx), .iss_opcode(iss_opcode), .iss_imm(iss_imm),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        flush         = 1'b0;
        disp_valid    = 1'b0;
        disp_src1_idx = '0;
        disp_src2_idx = '0;
        disp_src1_rdy = 1'b0;
        disp_src2_rdy = 1'b0;
        disp_dst_idx  = '0;
        disp_opcode   = '0;
        disp_imm      = '0;
        wake_valid    = '0;
        wake_tag      = '0;
        iss_ready     = 1'b0;
    endtask

    // Advance to the next falling edge with all inputs idle; caller then overrides.
    task automatic step();
        @(negedge clk);
        set_idle();
    endtask

    task automatic disp(input logic [PW-1:0] s1, input logic r1,
                        input logic [PW-1:0] s2, input logic r2,
                        input logic [PW-1:0] d, input logic [5:0] op, input logic [31:0] im);
        disp_valid    = 1'b1;
        disp_src1_idx = s1;
        disp_src1_rdy = r1;
        disp_src2_idx = s2;
        disp_src2_rdy = r2;
        disp_dst_idx  = d;
        disp_opcode   = op;
        disp_imm      = im;
    endtask

    task automatic wake(input int k, input logic [PW-1:0] tag);
        wake_valid[k]            = 1'b1;
        wake_tag[k*PW +: PW]     = tag;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        #1;
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk("rst_iss_dst", 32'(iss_dst_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: A ready at dispatch issues next cycle
        step(); disp(7'd5, 1, 7'd6, 1, 7'd10, 6'd3, 32'h1234); iss_ready = 1; #1;
        chk("a_not_yet", 32'(iss_valid), 0);
        step(); iss_ready = 1; #1;
        chk("a_valid", 32'(iss_valid), 1);
        chk("a_src1", 32'(iss_src1_idx), 5);
        chk("a_src2", 32'(iss_src2_idx), 6);
        chk("a_dst", 32'(iss_dst_idx), 10);
        chk("a_opc", 32'(iss_opcode), 3);
        chk("a_imm", iss_imm, 32'h1234);
        chk("a_occ1", 32'(occupancy), 1);
        step(); #1;
        chk("a_occ0", 32'(occupancy), 0);
        chk("a_gone", 32'(iss_valid), 0);

        // Wakeup: A waits on tag 7 (src2 is x0), B ready overtakes it
        step(); disp(7'd7, 0, 7'd0, 0, 7'd11, 6'd1, 32'd0); #1;
        step(); disp(7'd1, 1, 7'd2, 1, 7'd12, 6'd2, 32'd0); #1;
        chk("w_a_blocked", 32'(iss_valid), 0);
        step(); wake(2, 7'd7); iss_ready = 1; #1;
        chk("w_b_valid", 32'(iss_valid), 1);
        chk("w_b_first", 32'(iss_dst_idx), 12);
        step(); iss_ready = 1; #1;
        chk("w_a_valid", 32'(iss_valid), 1);
        chk("w_a_next", 32'(iss_dst_idx), 11);
        chk("w_occ1", 32'(occupancy), 1);
        step(); #1;
        chk("w_empty", 32'(iss_valid), 0);
        chk("w_occ0", 32'(occupancy), 0);

        // Same-cycle bypass: C's source 9 broadcast while dispatching
        step(); disp(7'd9, 0, 7'd3, 1, 7'd13, 6'd4, 32'd0); wake(0, 7'd9); iss_ready = 1; #1;
        chk("byp_not_yet", 32'(iss_valid), 0);
        step(); iss_ready = 1; #1;
        chk("byp_valid", 32'(iss_valid), 1);
        chk("byp_dst", 32'(iss_dst_idx), 13);
        step(); #1;
        chk("byp_occ0", 32'(occupancy), 0);

        // Fill: 8 entries waiting on tags 20..23
        for (int i = 0; i < 8; i++) begin
            step(); disp(7'(20 + i % 4), 0, 7'd0, 0, 7'(30 + i), 6'd5, 32'(i));
        end
        step(); disp(7'd1, 1, 7'd2, 1, 7'd99, 6'd6, 32'd0); #1;
        chk("full_ready", 32'(disp_ready), 0);
        chk("full_occ", 32'(occupancy), 8);
        chk("full_none", 32'(iss_valid), 0);
        step(); wake(0, 7'd20); wake(1, 7'd21); wake(2, 7'd22); wake(3, 7'd23); #1;
        chk("full_rejected_occ", 32'(occupancy), 8);
        chk("full_wake_cycle", 32'(iss_valid), 0);
        for (int h = 0; h < 2; h++) begin
            step(); #1;
            chk("hold_valid", 32'(iss_valid), 1);
            chk("hold_dst", 32'(iss_dst_idx), 30);
            chk("hold_occ", 32'(occupancy), 8);
        end
        for (int i = 0; i < 8; i++) begin
            step(); iss_ready = 1; #1;
            chk("drain_valid", 32'(iss_valid), 1);
            chk("drain_dst", 32'(iss_dst_idx), 32'(30 + i));
            chk("drain_occ", 32'(occupancy), 32'(8 - i));
            if (i == 1) chk("drain_disp_ready", 32'(disp_ready), 1);
        end
        step(); #1;
        chk("drain_empty", 32'(iss_valid), 0);
        chk("drain_occ0", 32'(occupancy), 0);

        // Age across slot reuse: P3 lands in slot 1 but is youngest
        step(); disp(7'd50, 0, 7'd0, 0, 7'd60, 6'd0, 32'd0);
        step(); disp(7'd1, 1, 7'd2, 1, 7'd61, 6'd0, 32'd0);
        step(); disp(7'd50, 0, 7'd0, 0, 7'd62, 6'd0, 32'd0); iss_ready = 1; #1;
        chk("age_p1", 32'(iss_dst_idx), 61);
        step(); disp(7'd50, 0, 7'd0, 0, 7'd63, 6'd0, 32'd0); #1;
        chk("age_occ2", 32'(occupancy), 2);
        chk("age_blocked", 32'(iss_valid), 0);
        step(); wake(1, 7'd50); iss_ready = 1; #1;
        chk("age_occ3", 32'(occupancy), 3);
        step(); iss_ready = 1; #1;
        chk("age_first", 32'(iss_dst_idx), 60);
        step(); iss_ready = 1; #1;
        chk("age_second", 32'(iss_dst_idx), 62);
        step(); iss_ready = 1; #1;
        chk("age_third", 32'(iss_dst_idx), 63);
        step(); #1;
        chk("age_empty", 32'(iss_valid), 0);

        // Flush with concurrent dispatch and issue
        for (int i = 0; i < 5; i++) begin
            step(); disp(7'd1, 1, 7'd2, 1, 7'(70 + i), 6'd0, 32'd0);
        end
        step(); #1;
        chk("fl_occ5", 32'(occupancy), 5);
        chk("fl_pre_valid", 32'(iss_valid), 1);
        step(); flush = 1; iss_ready = 1; disp(7'd1, 1, 7'd2, 1, 7'd75, 6'd0, 32'd0); #1;
        chk("fl_iss_valid", 32'(iss_valid), 0);
        chk("fl_iss_dst", 32'(iss_dst_idx), 0);
        step(); iss_ready = 1; #1;
        chk("fl_occ0", 32'(occupancy), 0);
        chk("fl_post_valid", 32'(iss_valid), 0);
        chk("fl_disp_ready", 32'(disp_ready), 1);

        // Asynchronous reset with 3 resident entries
        for (int i = 0; i < 3; i++) begin
            step(); disp(7'd1, 1, 7'd2, 1, 7'(80 + i), 6'd0, 32'd0);
        end
        step(); #1;
        chk("ar_occ3", 32'(occupancy), 3);
        chk("ar_pre_valid", 32'(iss_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_iss_valid", 32'(iss_valid), 0);
        chk("ar_occ", 32'(occupancy), 0);
        chk("ar_dst", 32'(iss_dst_idx), 0);
        chk("ar_disp_ready", 32'(disp_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); iss_ready = 1; #1;
            chk("ar_no_issue", 32'(iss_valid), 0);
        end
        step(); disp(7'd0, 0, 7'd0, 0, 7'd90, 6'd7, 32'hbeef); #1;
        step(); iss_ready = 1; #1;
        chk("ar_new_valid", 32'(iss_valid), 1);
        chk("ar_new_dst", 32'(iss_dst_idx), 90);
        chk("ar_new_imm", iss_imm, 32'hbeef);
        step(); #1;
        chk("ar_new_occ0", 32'(occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_issue_queue.md
# rs_issue_queue

Parametrised reservation station for the out-of-order core: holds dispatched uOPs until both physical source registers are ready, tracks readiness via per-cycle wakeup broadcasts from up to NUM_FUS functional units, and issues the oldest ready uOP each cycle toward register read. Sits between dispatch/rename and register read, generalising the fixed RS_ENTRIES/NUM_FUS/NUM_PREGS scheme into one configurable block with age-ordered select, same-cycle wakeup bypass and flush.

## Interface
- RS_ENTRIES, 8, number of entries (2..32)
- NUM_PREGS, 128, physical registers; PREG_W = $clog2(NUM_PREGS)
- NUM_WAKEUP, 4, wakeup broadcast ports (one per FU)
- OPC_W, 6, opcode field width (instr_opcode encoding)
- IMM_W, 32, immediate width
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (mispredict recovery)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry free; handshake = disp_valid & disp_ready
- disp_src1_idx, disp_src2_idx  in  PREG_W  source physical tags
- disp_src1_rdy, disp_src2_rdy  in  1  source already ready at rename
- disp_dst_idx  in  PREG_W  destination physical tag
- disp_opcode  in  OPC_W  opcode
- disp_imm  in  IMM_W  immediate
- wake_valid  in  NUM_WAKEUP  per-port broadcast valid
- wake_tag  in  NUM_WAKEUP*PREG_W  broadcast tags, port k at [k*PREG_W +: PREG_W]
- iss_valid  out  1  a ready entry is selected
- iss_ready  in  1  downstream accepts; handshake = iss_valid & iss_ready
- iss_src1_idx, iss_src2_idx, iss_dst_idx  out  PREG_W  selected entry tags
- iss_opcode  out  OPC_W; iss_imm  out  IMM_W
- occupancy  out  $clog2(RS_ENTRIES+1)  valid entry count

## Operation
- Entry state: valid, src1_rdy, src2_rdy, tags, opcode, imm; age matrix age[i][j]=1 means i older than j.
- Dispatch: on handshake, write lowest-index free entry; set its age row to 1 for every currently valid entry column... i.e. all existing valid entries become older than it (age[j][new]=1, age[new][j]=0).
- Wakeup: each edge, any valid entry whose srcN tag equals wake_tag[k] with wake_valid[k] sets srcN_rdy. Same-cycle bypass: a dispatching uOP whose source matches a concurrent broadcast is written ready.
- Tag 0 (x0) is always ready: source tag 0 sets rdy at dispatch regardless of disp_srcN_rdy.
- Select: candidate = valid & src1_rdy & src2_rdy; grant the candidate older than all other candidates. iss_valid = any candidate & !flush; iss_* outputs are the granted entry's fields (combinational from registered state). Unselected: outputs 0.
- Issue: on handshake, granted entry valid cleared at the edge. If iss_ready low, selection may change next cycle (an older entry may become ready); no hold requirement.
- Full: disp_ready = (occupancy < RS_ENTRIES), registered-state based; a full queue does not accept a dispatch even if an issue frees an entry that cycle.
- Flush: at the edge, all valid bits cleared, occupancy 0; dispatch and issue in the flush cycle have no effect (disp_ready may be high but is ignored).
- occupancy: +1 on dispatch, -1 on issue, both same cycle = unchanged.

## Timing
- Reset (rst_n low, async): all valid/rdy bits 0, age matrix 0, occupancy 0, iss_valid 0, iss_* 0, disp_ready 1.
- Dispatch with both sources ready in cycle N -> iss_valid earliest cycle N+1.
- Wakeup in cycle N for a resident entry -> eligible cycle N+1.
- Issue handshake in cycle N -> entry free, disp_ready reflects it cycle N+1.
- One issue and one dispatch per cycle max; no combinational path from iss_ready to disp_ready.

## Test plan
- Reset, dispatch A(src 5 rdy, src 6 rdy) with iss_ready=1 -> iss_valid=1 next cycle with A's tags, occupancy 1->0.
- Dispatch A(src1=7 not ready), then B(all ready); broadcast tag 7 on port 2 -> B issues first, A issues the cycle after wake+1; tag 0 sources never block.
- Dispatch C(src1=9) in the same cycle wake_tag[0]=9 valid -> C issues the following cycle.
- Fill all 8 entries with not-ready uOPs -> disp_ready=0, occupancy 8; wake all in one cycle with 4 ports -> issues in dispatch order, one per cycle; hold iss_ready=0 two cycles -> no entry lost.
- Dispatch 5 entries, assert flush with iss_ready=1 and disp_valid=1 -> iss_valid=0 that cycle, occupancy 0 next cycle, nothing issued.
- Deassert rst_n mid-operation with 3 entries resident -> outputs return to reset values immediately, no issue after release until new dispatch.
